// File: rtl/daq_event_framer_pkg.sv
// Shared DAQ framing definitions: FSM states, field widths, version and magic defaults.
// Also holds the payload checksum fold used by the framer.
package daq_event_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } daq_state_e;

    localparam int DATA_W      = 64;
    localparam int HDR_MAGIC_W = 16;
    localparam int TRL_MAGIC_W = 8;
    localparam int FPGA_ID_W   = 8;
    localparam int VERSION_W   = 8;
    localparam int EVT_CNT_W   = 32;
    localparam int CSUM_W      = 32;
    localparam int WCNT_W      = 16;

    localparam logic [VERSION_W-1:0]   DAQ_VERSION       = 8'h01;
    localparam logic [HDR_MAGIC_W-1:0] DEF_HDR_MAGIC     = 16'hA55A;
    localparam logic [TRL_MAGIC_W-1:0] DEF_TRL_MAGIC     = 8'hE0;

    function automatic logic [CSUM_W-1:0] fold_xor(input logic [DATA_W-1:0] d);
        return d[63:32] ^ d[31:0];
    endfunction

endpackage

// File: rtl/daq_event_framer.sv
// Wraps each upstream DMA event in a header word and a trailer word carrying
// word count, overflow flag and XOR checksum, through a single output register.
module daq_event_framer
    import daq_event_framer_pkg::*;
#(
    parameter logic [HDR_MAGIC_W-1:0] HDR_MAGIC = DEF_HDR_MAGIC,
    parameter logic [TRL_MAGIC_W-1:0] TRL_MAGIC = DEF_TRL_MAGIC
) (
    input  logic                 dma_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [FPGA_ID_W-1:0] fpga_id,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic [EVT_CNT_W-1:0] event_count,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    // Handshake: a word moves on any edge where valid && ready are both high.
    // The sender keeps valid/data/last stable until that edge; ready may depend
    // combinationally on the receiver's state and on m_ready.

    daq_state_e            state_q;
    logic                  m_valid_q;
    logic [DATA_W-1:0]     m_data_q;
    logic                  m_last_q;
    logic [EVT_CNT_W-1:0]  event_count_q;
    logic [CSUM_W-1:0]     checksum_q;
    logic [WCNT_W-1:0]     word_count_q;
    logic                  overflow_q;

    logic                  out_free;
    logic                  s_accept;
    logic [CSUM_W-1:0]     checksum_d;
    logic [WCNT_W-1:0]     word_count_d;
    logic                  word_sat;
    logic [DATA_W-1:0]     header_d;
    logic [DATA_W-1:0]     trailer_d;

    assign out_free     = !m_valid_q || m_ready;
    assign s_ready      = (state_q == ST_PAYLOAD) && out_free;
    assign s_accept     = s_valid && s_ready;
    assign checksum_d   = checksum_q ^ fold_xor(s_data);
    assign word_sat     = (word_count_q == {WCNT_W{1'b1}});
    assign word_count_d = word_sat ? word_count_q : word_count_q + 16'd1;
    assign header_d     = {HDR_MAGIC, fpga_id, DAQ_VERSION, event_count_q};
    assign trailer_d    = {TRL_MAGIC, 7'h0, overflow_q, word_count_q, checksum_q};

    always_ff @(posedge dma_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
            event_count_q <= '0;
            checksum_q    <= '0;
            word_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            // A transferred word retires unless a new load below replaces it.
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable && s_valid && out_free) begin
                        m_valid_q    <= 1'b1;
                        m_data_q     <= header_d;
                        m_last_q     <= 1'b0;
                        checksum_q   <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        state_q      <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (s_accept) begin
                        m_valid_q    <= 1'b1;
                        m_data_q     <= s_data;
                        m_last_q     <= 1'b0;
                        checksum_q   <= checksum_d;
                        word_count_q <= word_count_d;
                        if (word_sat) begin
                            overflow_q <= 1'b1;
                        end
                        if (s_last) begin
                            state_q <= ST_TRAILER;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (out_free) begin
                        m_valid_q     <= 1'b1;
                        m_data_q      <= trailer_d;
                        m_last_q      <= 1'b1;
                        event_count_q <= event_count_q + 32'd1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign event_count = event_count_q;
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: doc/daq_event_framer.md
DAQ_EVENT_FRAMER -- requirements
Module: daq_event_framer

Interface
REQ-001 Parameter HDR_MAGIC, default 16'hA55A: header word bits [63:48].
REQ-002 Parameter TRL_MAGIC, default 8'hE0: trailer word bits [63:56].
REQ-003 dma_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  permits framing of new events; sampled only in IDLE.
REQ-006 fpga_id  in  8  placed in header; quasi-static.
REQ-007 s_valid  in  1  upstream DMA word valid (DAQ dma_valid).
REQ-008 s_data  in  64  upstream DMA payload word (DAQ dma_data).
REQ-009 s_last  in  1  last payload word of event (DAQ dma_done).
REQ-010 s_ready  out  1  upstream accept (drives DAQ dma_ready).
REQ-011 m_valid  out  1  framed word valid to host DMA engine.
REQ-012 m_data  out  64  framed word.
REQ-013 m_last  out  1  marks trailer word.
REQ-014 m_ready  in  1  host DMA accept.
REQ-015 event_count  out  32  number of trailers loaded since reset.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 Output is a single register stage (m_valid/m_data/m_last); "out_free" = !m_valid || m_ready; the register loads only when out_free.
REQ-018 A word transfers downstream when m_valid && m_ready; m_valid, m_data and m_last hold stable while m_valid && !m_ready.
REQ-019 States: IDLE, PAYLOAD, TRAILER.
REQ-020 IDLE: when enable && s_valid && out_free, load header, go to PAYLOAD; s_ready = 0 in IDLE.
REQ-021 Header = {HDR_MAGIC, fpga_id, 8'h01, event_count}; it is visible on m_data one cycle after the loading edge.
REQ-022 PAYLOAD: s_ready = out_free (combinational from m_ready); on s_valid && s_ready, load s_data with m_last = 0, one-cycle latency.
REQ-023 PAYLOAD: accepted word with s_last = 1 moves the FSM to TRAILER.
REQ-024 Checksum: 32-bit register cleared at header load; XORs s_data[63:32] ^ s_data[31:0] on each accepted word.
REQ-025 Word count: 16-bit counter cleared at header load, incremented per accepted word, saturating at 16'hFFFF; the overflow flag is set when an increment is attempted at 16'hFFFF.
REQ-026 TRAILER: s_ready = 0; when out_free, load {TRL_MAGIC, 7'h0, overflow, word_count, checksum} with m_last = 1, increment event_count (wraps at 2^32), go to IDLE.
REQ-027 Back-to-back events: the next header may load on the cycle after the trailer load, so the IDLE bubble is at most one cycle.
REQ-028 Deasserting enable mid-event does not abort; the event completes through its trailer, then the FSM stays in IDLE.
REQ-029 s_valid while in TRAILER or IDLE is not accepted; upstream holds it per valid/ready rules.

Reset
REQ-030 Reset forces the following immediately (asynchronously): state = IDLE, m_valid = 0, m_last = 0, m_data = 0, s_ready = 0, event_count = 0, busy = 0, checksum = 0, word_count = 0, overflow = 0.
REQ-031 Reset mid-event discards the partial event with no trailer emitted; after release, the next header carries event_count 0.

Structure
REQ-032 A shared DAQ package holds the state enumeration, header/trailer field widths, the version constant 8'h01, and default magic values.
REQ-033 The design has no sub-modules; the optional output register is the sole natural candidate, named daq_out_reg64.

Verification
REQ-034 Setup: fpga_id = 8'h3C, m_ready = 1. Stimulus: a three-word event 64'h0000_0001_0000_0002, 64'h0000_0010_0000_0000, 64'h0000_0000_0000_0100 (last). Required output: header 64'hA55A_3C01_0000_0000, then the three payload words, then trailer 64'hE000_0003_0000_0113 with m_last = 1; event_count = 1.
REQ-035 Stimulus: same event with m_ready toggling 1010... Required: identical output sequence, no word lost or duplicated, and m_data stable while stalled.
REQ-036 Stimulus: two events back-to-back with s_valid held high. Required: the second header carries event number 1, with at most one idle cycle between the first trailer and the second header.
REQ-037 Stimulus: 65537-word event. Required: trailer word_count = 16'hFFFF and overflow = 1.
REQ-038 Stimulus: assert reset after two payload words. Required: m_valid = 0 immediately and no trailer; the next event's header shows event_count 0.
REQ-039 Stimulus: enable = 0 with s_valid = 1 in IDLE. Required: s_ready = 0 and m_valid = 0; after raising enable, the header appears one cycle later.
